// File: rtl/nes_dma_ctrl_if.sv
// Purpose: DMC fetch handshake plus DMA bus signals between nes_dma_ctrl and its neighbours.
// Latency: none (wires only).
// Backpressure: none; the CPU is stalled through cpu_rdy on the controller itself.
//
// Optional feature macro: NES_DMA_OAM_EN adds the sprite (OAM) DMA signals.
// master modport: the DMA controller. slave modport: the DMC channel + memory bus side.
//   dmc_req/dmc_addr   DMC -> ctrl   level request and sample address
//   dmc_ack/dmc_data   ctrl -> DMC   one-ce pulse with the fetched byte
//   bus_sel/bus_addr/bus_rd          ctrl -> bus, DMA owns the address bus
//   bus_din            bus -> ctrl   read data, valid inside the bus_rd cycle
//   oam_start/oam_page CPU -> ctrl   $4014 write (OAM build only)
//   bus_wr/bus_dout/oam_active       ctrl -> bus (OAM build only)

interface nes_dma_ctrl_if;
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic        dmc_ack;
    logic [7:0]  dmc_data;
    logic        bus_sel;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic [7:0]  bus_din;
`ifdef NES_DMA_OAM_EN
    logic        oam_start;
    logic [7:0]  oam_page;
    logic        bus_wr;
    logic [7:0]  bus_dout;
    logic        oam_active;

    modport master (
        input  dmc_req, dmc_addr, bus_din, oam_start, oam_page,
        output dmc_ack, dmc_data, bus_sel, bus_addr, bus_rd, bus_wr, bus_dout, oam_active
    );
    modport slave (
        output dmc_req, dmc_addr, bus_din, oam_start, oam_page,
        input  dmc_ack, dmc_data, bus_sel, bus_addr, bus_rd, bus_wr, bus_dout, oam_active
    );
`else
    modport master (
        input  dmc_req, dmc_addr, bus_din,
        output dmc_ack, dmc_data, bus_sel, bus_addr, bus_rd
    );
    modport slave (
        output dmc_req, dmc_addr, bus_din,
        input  dmc_ack, dmc_data, bus_sel, bus_addr, bus_rd
    );
`endif
endinterface

// File: rtl/nes_dma_ctrl.sv
// Purpose: 2A03 DMA controller; halts the CPU via cpu_rdy and fetches DMC sample bytes (optionally $4014 sprite DMA).
// Latency: 3 ce cycles of CPU stall (4 with alignment) plus HALT extension on CPU write cycles; ack on the edge ending the get cycle.
// Backpressure: dmc_req is a level held until dmc_ack; CPU write cycles extend HALT; ce==0 freezes everything.
//
// Optional feature macro: NES_DMA_OAM_EN (sprite DMA, 256 get/put pairs to OAM_REG_ADDR, DMC has priority on get cycles).
// Ports:
//   clk, reset (sync, active-low), ce (CPU cycle enable)
//   odd_or_even   0 = get cycle, 1 = put cycle
//   cpu_rw        CPU's current bus cycle, 1 = read (only reads may be halted)
//   cpu_rdy       registered, 0 = CPU halted
//   dma           nes_dma_ctrl_if.master: DMC handshake and DMA bus (see interface file)

module nes_dma_ctrl #(
    parameter logic [15:0] OAM_REG_ADDR = 16'h2004
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    input  logic           odd_or_even,
    input  logic           cpu_rw,
    output logic           cpu_rdy,
    nes_dma_ctrl_if.master dma
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HALT  = 2'd1,
        DUMMY = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        cpu_rdy_q;
    logic        dmc_ack_q;
    logic [7:0]  dmc_data_q;

    // Sprite DMA state; tied off when the feature is not built.
    logic        oam_act;
    logic        oam_full;     // a byte has been read and awaits its put cycle
    logic        oam_go;       // accepted $4014 start
    logic [7:0]  oam_cnt;
    logic [7:0]  oam_pg;

    logic        dmc_pend;
    logic        in_read;
    logic        get_cyc;
    logic        put_cyc;
    logic        dmc_get;
    logic        oam_rd;
    logic        oam_wr;
    logic        oam_last;
    logic        oam_act_d;
    logic        bus_rd_w;
    logic [15:0] bus_addr_w;

    // A request still high during its own ack cycle is stale: the DMC has
    // not yet had a chance to drop or re-present it.
    assign dmc_pend = dma.dmc_req && !dmc_ack_q;

    assign in_read = (state_q == READ);
    assign get_cyc = !odd_or_even;
    assign put_cyc = odd_or_even;

    // DMC wins a get cycle; the sprite read slides to the next get cycle,
    // which leaves the intervening put cycle idle.
    assign dmc_get  = in_read && get_cyc && dmc_pend;
    assign oam_rd   = in_read && get_cyc && !dmc_pend && oam_act && !oam_full;
    assign oam_wr   = in_read && put_cyc && oam_full;
    assign oam_last = oam_wr && (oam_cnt == 8'hFF);

    assign oam_act_d = oam_go || (oam_act && !oam_last);

`ifdef NES_DMA_OAM_EN
    logic [7:0] oam_byte;

    // A start while a transfer is running is dropped.
    assign oam_go = dma.oam_start && !oam_act;

    always_ff @(posedge clk) begin
        if (!reset) begin
            oam_act  <= 1'b0;
            oam_full <= 1'b0;
            oam_cnt  <= 8'h00;
            oam_pg   <= 8'h00;
            oam_byte <= 8'h00;
        end else if (ce) begin
            oam_act <= oam_act_d;
            if (oam_go) begin
                oam_pg   <= dma.oam_page;
                oam_cnt  <= 8'h00;
                oam_full <= 1'b0;
            end
            if (oam_rd) begin
                oam_byte <= dma.bus_din;
                oam_full <= 1'b1;
            end
            if (oam_wr) begin
                oam_full <= 1'b0;
                oam_cnt  <= oam_cnt + 8'd1;   // wraps to 0 on the final put
            end
        end
    end

    assign dma.bus_wr     = oam_wr;
    assign dma.bus_dout   = oam_wr ? oam_byte : 8'h00;
    assign dma.oam_active = oam_act;
`else
    assign oam_act  = 1'b0;
    assign oam_full = 1'b0;
    assign oam_go   = 1'b0;
    assign oam_cnt  = 8'h00;
    assign oam_pg   = 8'h00;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dmc_pend || oam_go) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                // RDY only stops the CPU on a read; keep waiting through writes.
                if (!dmc_pend && !oam_act) begin
                    state_d = IDLE;
                end else if (cpu_rw) begin
                    // Sprite-only DMA has no dummy cycle.
                    state_d = dmc_pend ? DUMMY : READ;
                end
            end
            DUMMY: begin
                if (!dmc_pend && !oam_act) begin
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            READ: begin
                // Leave once neither DMA has work beyond this cycle.
                if (!(dmc_pend && !dmc_get) && !oam_act_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cpu_rdy_q  <= 1'b1;
            dmc_ack_q  <= 1'b0;
            dmc_data_q <= 8'h00;
        end else if (ce) begin
            state_q   <= state_d;
            cpu_rdy_q <= (state_d == IDLE);
            dmc_ack_q <= dmc_get;
            if (dmc_get) begin
                dmc_data_q <= dma.bus_din;
            end
        end
    end

    // Bus drive is combinational from state, counters and the current phase.
    always_comb begin
        bus_addr_w = 16'h0000;
        if (dmc_get) begin
            bus_addr_w = dma.dmc_addr;
        end else if (oam_rd) begin
            bus_addr_w = {oam_pg, oam_cnt};
        end else if (oam_wr) begin
            bus_addr_w = OAM_REG_ADDR;
        end
    end

    assign bus_rd_w     = dmc_get || oam_rd;
    assign dma.bus_rd   = bus_rd_w;
    assign dma.bus_sel  = bus_rd_w || oam_wr;
    assign dma.bus_addr = bus_addr_w;
    assign dma.dmc_ack  = dmc_ack_q;
    assign dma.dmc_data = dmc_data_q;
    assign cpu_rdy      = cpu_rdy_q;

endmodule
